// File: rtl/wave_fetch_ctrl.sv
// Sector-based wave loader: fetches 512-byte sectors and writes the first `width` bytes into the sample buffer.
// Optional WAVE_FETCH_CHECKSUM_EN adds checksum_out, the 16-bit sum of all bytes written for the current load.
module wave_fetch_ctrl #(
  parameter int unsigned WW_WIDTH = 18,
  parameter int unsigned WS_WIDTH = 30
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                update_trig_in,
  input  logic [WS_WIDTH-1:0] wave_start_in,
  input  logic [WW_WIDTH-1:0] wave_width_in,
  output logic                rd_req_valid_out,
  input  logic                rd_req_ready_in,
  output logic [WS_WIDTH-10:0] rd_req_addr_out,
  input  logic                rd_data_valid_in,
  input  logic [7:0]          rd_data_in,
  output logic                buf_we_out,
  output logic [WW_WIDTH-1:0] buf_addr_out,
  output logic [7:0]          buf_data_out,
  output logic                busy_out,
  output logic                done_out
`ifdef WAVE_FETCH_CHECKSUM_EN
  ,
  output logic [15:0]         checksum_out
`endif
);

  localparam int unsigned SA_W  = WS_WIDTH - 9;
  localparam int unsigned CMP_W = ((WS_WIDTH > WW_WIDTH) ? WS_WIDTH : WW_WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, REQ, RECV, DONE} state_t;

  state_t              r_state, w_state_nxt;
  logic [SA_W-1:0]     r_base, w_base_nxt;
  logic [WW_WIDTH-1:0] r_width, w_width_nxt;
  logic [SA_W-1:0]     r_sector, w_sector_nxt;
  logic [8:0]          r_byte, w_byte_nxt;
  logic                r_pend, w_pend_nxt;
  logic                w_we_nxt;
  logic [WW_WIDTH-1:0] w_waddr_nxt;
  logic [7:0]          w_wdata_nxt;

  logic                r_req_valid;
  logic [SA_W-1:0]     r_req_addr;
  logic                r_buf_we;
  logic [WW_WIDTH-1:0] r_buf_addr;
  logic [7:0]          r_buf_data;
  logic                r_busy;
  logic                r_done;

  logic [WS_WIDTH-1:0] w_offset;
  logic                w_in_window;
  logic                w_more;
  logic                w_pend_eff;
  logic                w_unused_lsb;

  // Stream offset of the current byte within the whole load
  assign w_offset     = {r_sector, r_byte};
  assign w_in_window  = CMP_W'(w_offset) < CMP_W'(r_width);
  assign w_more       = (CMP_W'(w_offset) + CMP_W'(1)) < CMP_W'(r_width);
  assign w_pend_eff   = r_pend | update_trig_in;
  assign w_unused_lsb = ^wave_start_in[8:0];

  always_comb begin
    w_state_nxt  = r_state;
    w_base_nxt   = r_base;
    w_width_nxt  = r_width;
    w_sector_nxt = r_sector;
    w_byte_nxt   = r_byte;
    w_pend_nxt   = r_pend;
    w_we_nxt     = 1'b0;
    w_waddr_nxt  = r_buf_addr;
    w_wdata_nxt  = r_buf_data;

    // Any trigger relatches the load parameters, whatever the state
    if (update_trig_in) begin
      w_base_nxt  = wave_start_in[WS_WIDTH-1:9];
      w_width_nxt = wave_width_in;
    end

    case (r_state)
      IDLE, DONE: begin
        w_state_nxt = IDLE;
        if (update_trig_in) begin
          w_sector_nxt = '0;
          w_byte_nxt   = '0;
          w_pend_nxt   = 1'b0;
          w_state_nxt  = (wave_width_in == '0) ? DONE : REQ;
        end
      end
      REQ: begin
        if (rd_req_ready_in) begin
          // The sector is already granted; a coincident trigger must drain it first
          w_state_nxt = RECV;
          w_byte_nxt  = '0;
          w_pend_nxt  = update_trig_in;
        end else if (update_trig_in) begin
          w_sector_nxt = '0;
          if (wave_width_in == '0) w_state_nxt = DONE;
        end
      end
      RECV: begin
        w_pend_nxt = w_pend_eff;
        if (rd_data_valid_in) begin
          w_byte_nxt = r_byte + 9'd1;
          if (!w_pend_eff && w_in_window) begin
            w_we_nxt    = 1'b1;
            w_waddr_nxt = WW_WIDTH'(w_offset);
            w_wdata_nxt = rd_data_in;
          end
          if (r_byte == 9'd511) begin
            if (w_pend_eff) begin
              w_pend_nxt   = 1'b0;
              w_sector_nxt = '0;
              w_state_nxt  = (w_width_nxt == '0) ? DONE : REQ;
            end else if (w_more) begin
              w_sector_nxt = r_sector + SA_W'(1);
              w_state_nxt  = REQ;
            end else begin
              w_state_nxt = DONE;
            end
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state     <= IDLE;
      r_base      <= '0;
      r_width     <= '0;
      r_sector    <= '0;
      r_byte      <= '0;
      r_pend      <= 1'b0;
      r_req_valid <= 1'b0;
      r_req_addr  <= '0;
      r_buf_we    <= 1'b0;
      r_buf_addr  <= '0;
      r_buf_data  <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_base      <= w_base_nxt;
      r_width     <= w_width_nxt;
      r_sector    <= w_sector_nxt;
      r_byte      <= w_byte_nxt;
      r_pend      <= w_pend_nxt;
      r_req_valid <= (w_state_nxt == REQ);
      r_req_addr  <= w_base_nxt + w_sector_nxt;
      r_buf_we    <= w_we_nxt;
      r_buf_addr  <= w_waddr_nxt;
      r_buf_data  <= w_wdata_nxt;
      r_busy      <= (w_state_nxt == REQ) || (w_state_nxt == RECV);
      r_done      <= (w_state_nxt == DONE);
    end
  end

  assign rd_req_valid_out = r_req_valid;
  assign rd_req_addr_out  = r_req_addr;
  assign buf_we_out       = r_buf_we;
  assign buf_addr_out     = r_buf_addr;
  assign buf_data_out     = r_buf_data;
  assign busy_out         = r_busy;
  assign done_out         = r_done;

`ifdef WAVE_FETCH_CHECKSUM_EN
  logic [15:0] r_csum;

  // Cleared by every trigger; accumulates exactly the bytes sent to the buffer
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_csum <= '0;
    end else if (update_trig_in) begin
      r_csum <= '0;
    end else if (w_we_nxt) begin
      r_csum <= r_csum + 16'(rd_data_in);
    end
  end

  assign checksum_out = r_csum;
`endif

endmodule

// File: tb/tb_wave_fetch_ctrl.sv
// Randomized self-checking bench for wave_fetch_ctrl against a sector/offset reference model.
module tb_wave_fetch_ctrl;
  localparam int unsigned WW     = 18;
  localparam int unsigned WS     = 30;
  localparam int unsigned SA     = WS - 9;
  localparam int unsigned OUTS_W = 4 + SA + WW + 8;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          update_trig_in;
  logic [WS-1:0] wave_start_in;
  logic [WW-1:0] wave_width_in;
  logic          rd_req_valid_out;
  logic          rd_req_ready_in;
  logic [SA-1:0] rd_req_addr_out;
  logic          rd_data_valid_in;
  logic [7:0]    rd_data_in;
  logic          buf_we_out;
  logic [WW-1:0] buf_addr_out;
  logic [7:0]    buf_data_out;
  logic          busy_out;
  logic          done_out;
`ifdef WAVE_FETCH_CHECKSUM_EN
  logic [15:0]   checksum_out;
`endif

  int checks   = 0;
  int failures = 0;

  logic [SA-1:0] obs_req[$];
  logic [WW-1:0] obs_wa[$];
  logic [7:0]    obs_wd[$];
  int            obs_done;
  int            obs_busy;
  logic [SA-1:0] exp_req[$];
  logic [WW-1:0] exp_wa[$];
  logic [7:0]    exp_wd[$];
  logic [15:0]   exp_sum;
  logic [7:0]    sent[$];

  wave_fetch_ctrl #(.WW_WIDTH(WW), .WS_WIDTH(WS)) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .update_trig_in  (update_trig_in),
    .wave_start_in   (wave_start_in),
    .wave_width_in   (wave_width_in),
    .rd_req_valid_out(rd_req_valid_out),
    .rd_req_ready_in (rd_req_ready_in),
    .rd_req_addr_out (rd_req_addr_out),
    .rd_data_valid_in(rd_data_valid_in),
    .rd_data_in      (rd_data_in),
    .buf_we_out      (buf_we_out),
    .buf_addr_out    (buf_addr_out),
    .buf_data_out    (buf_data_out),
    .busy_out        (busy_out),
    .done_out        (done_out)
`ifdef WAVE_FETCH_CHECKSUM_EN
    ,
    .checksum_out    (checksum_out)
`endif
  );

  always #5 clk_in = ~clk_in;

  // Activity log sampled on the falling edge
  always @(negedge clk_in) begin
    if (!rst_in) begin
      if (rd_req_valid_out && rd_req_ready_in) obs_req.push_back(rd_req_addr_out);
      if (buf_we_out) begin
        obs_wa.push_back(buf_addr_out);
        obs_wd.push_back(buf_data_out);
      end
      if (done_out) obs_done++;
      if (busy_out) obs_busy++;
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic clear_logs();
    obs_req.delete(); obs_wa.delete(); obs_wd.delete();
    exp_req.delete(); exp_wa.delete(); exp_wd.delete();
    sent.delete();
    obs_done = 0; obs_busy = 0; exp_sum = '0;
  endtask

  task automatic send_trigger(input logic [WS-1:0] s, input logic [WW-1:0] w);
    wave_start_in  = s;
    wave_width_in  = w;
    update_trig_in = 1'b1;
    tick();
    update_trig_in = 1'b0;
    wave_start_in  = WS'($urandom);
    wave_width_in  = WW'($urandom);
  endtask

  task automatic serve_request(input int delay);
    int n;
    n = 0;
    while (rd_req_valid_out !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    if (rd_req_valid_out !== 1'b1) begin
      checks++; failures++;
      $display("FAIL req_timeout valid=%b required=1", rd_req_valid_out);
    end else begin
      repeat (delay) tick();
      rd_req_ready_in = 1'b1;
      tick();
      rd_req_ready_in = 1'b0;
    end
  endtask

  task automatic feed(input int n, input bit incr);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        rd_data_valid_in = 1'b0;
        rd_data_in = 8'($urandom);
        tick();
      end
      rd_data_valid_in = 1'b1;
      rd_data_in = incr ? 8'(sent.size() + 1) : 8'($urandom);
      sent.push_back(rd_data_in);
      tick();
    end
    rd_data_valid_in = 1'b0;
  endtask

  // Reference: nsec requests at floor(start/512)+i mod 2^SA; writes k -> sent[first+k]
  task automatic add_expect(input logic [WS-1:0] start, input int nsec, input int nwr, input int first);
    longint base;
    base = longint'(start) / 512;
    for (int i = 0; i < nsec; i++) exp_req.push_back(SA'((base + i) % (longint'(1) << SA)));
    for (int k = 0; k < nwr; k++) begin
      exp_wa.push_back(WW'(k));
      exp_wd.push_back(sent[first + k]);
      exp_sum += 16'(sent[first + k]);
    end
  endtask

  task automatic test_reset();
    logic [OUTS_W-1:0] outs;
    rst_in = 1'b1;
    repeat (2) tick();
    outs = {rd_req_valid_out, buf_we_out, busy_out, done_out, rd_req_addr_out, buf_addr_out, buf_data_out};
    checks++;
    if (outs !== '0) begin failures++; $display("FAIL reset_outputs got=%h required=0", outs); end
    rst_in = 1'b0;
    repeat (2) tick();
    outs = {rd_req_valid_out, buf_we_out, busy_out, done_out, rd_req_addr_out, buf_addr_out, buf_data_out};
    checks++;
    if (outs !== '0) begin failures++; $display("FAIL idle_outputs got=%h required=0", outs); end
  endtask

  task automatic test_loads();
    logic [WS-1:0] s;
    int w, d, nsec;
    bit inc;
    string tag;
    for (int t = 0; t < 9; t++) begin
      case (t)
        0: begin s = 30'h0004_0000; w = 4;    d = 0; inc = 1'b1; end
        1: begin s = 30'h0008_0000; w = 1024; d = 0; inc = 1'b0; end
        2: begin s = 30'h0012_34AB; w = 700;  d = 3; inc = 1'b0; end
        3: begin s = 30'h3FFF_FFFF; w = 513;  d = 1; inc = 1'b0; end
        4: begin s = WS'($urandom); w = 512;  d = 0; inc = 1'b0; end
        5: begin s = WS'($urandom); w = 1;    d = 2; inc = 1'b0; end
        default: begin s = WS'($urandom); w = int'($urandom_range(2, 1500)); d = int'($urandom_range(0, 5)); inc = 1'b0; end
      endcase
      tag = $sformatf("load%0d", t);
      clear_logs();
      send_trigger(s, WW'(w));
      checks++;
      if (busy_out !== 1'b1) begin failures++; $display("FAIL %s busy_after_trig got=%b required=1", tag, busy_out); end
      nsec = (w + 511) / 512;
      for (int k = 0; k < nsec; k++) begin
        serve_request(d);
        feed(512, inc);
      end
      checks++;
      if (done_out !== 1'b1 || busy_out !== 1'b0)
        begin failures++; $display("FAIL %s done_at_end got=%b busy=%b required done=1 busy=0", tag, done_out, busy_out); end
      tick();
      checks++;
      if (done_out !== 1'b0) begin failures++; $display("FAIL %s done_pulse_len got=%b required=0", tag, done_out); end
      add_expect(s, nsec, w, 0);
      checks++;
      if (obs_req.size() != exp_req.size())
        begin failures++; $display("FAIL %s req_count got=%0d required=%0d", tag, obs_req.size(), exp_req.size()); end
      foreach (exp_req[i]) if (i < obs_req.size()) begin
        checks++;
        if (obs_req[i] !== exp_req[i])
          begin failures++; $display("FAIL %s req_addr[%0d] got=%h required=%h", tag, i, obs_req[i], exp_req[i]); end
      end
      checks++;
      if (obs_wa.size() != exp_wa.size())
        begin failures++; $display("FAIL %s write_count got=%0d required=%0d", tag, obs_wa.size(), exp_wa.size()); end
      foreach (exp_wa[i]) if (i < obs_wa.size()) begin
        checks++;
        if ({obs_wa[i], obs_wd[i]} !== {exp_wa[i], exp_wd[i]})
          begin failures++; $display("FAIL %s write[%0d] got=%h/%h required=%h/%h", tag, i, obs_wa[i], obs_wd[i], exp_wa[i], exp_wd[i]); end
      end
      checks++;
      if (obs_done != 1) begin failures++; $display("FAIL %s done_count got=%0d required=1", tag, obs_done); end
`ifdef WAVE_FETCH_CHECKSUM_EN
      checks++;
      if (checksum_out !== exp_sum) begin failures++; $display("FAIL %s checksum got=%h required=%h", tag, checksum_out, exp_sum); end
`endif
    end
  endtask

  task automatic test_zero_width();
    clear_logs();
    send_trigger(WS'($urandom), '0);
    checks++;
    if (done_out !== 1'b1 || busy_out !== 1'b0)
      begin failures++; $display("FAIL zero_done got=%b busy=%b required done=1 busy=0", done_out, busy_out); end
    tick();
    checks++;
    if (done_out !== 1'b0) begin failures++; $display("FAIL zero_done_len got=%b required=0", done_out); end
    feed(20, 1'b0);
    repeat (2) tick();
    checks++;
    if (obs_req.size() != 0 || obs_busy != 0 || obs_done != 1 || obs_wa.size() != 0)
      begin failures++; $display("FAIL zero_activity req=%0d busy=%0d done=%0d writes=%0d required 0/0/1/0", obs_req.size(), obs_busy, obs_done, obs_wa.size()); end
  endtask

  task automatic test_ready_stall();
    logic [WS-1:0] s;
    int w;
    clear_logs();
    s = WS'($urandom);
    w = int'($urandom_range(1, 512));
    send_trigger(s, WW'(w));
    for (int c = 1; c <= 21; c++) begin
      checks++;
      if (rd_req_valid_out !== 1'b1 || rd_req_addr_out !== SA'(s >> 9))
        begin failures++; $display("FAIL stall_cycle%0d valid=%b addr=%h required valid=1 addr=%h", c, rd_req_valid_out, rd_req_addr_out, SA'(s >> 9)); end
      if (c < 21) tick();
    end
    rd_req_ready_in = 1'b1;
    tick();
    rd_req_ready_in = 1'b0;
    checks++;
    if (rd_req_valid_out !== 1'b0 || busy_out !== 1'b1)
      begin failures++; $display("FAIL stall_accept valid=%b busy=%b required valid=0 busy=1", rd_req_valid_out, busy_out); end
    feed(512, 1'b0);
    tick();
    checks++;
    if (obs_req.size() != 1 || obs_wa.size() != w || obs_done != 1)
      begin failures++; $display("FAIL stall_load req=%0d writes=%0d done=%0d required 1/%0d/1", obs_req.size(), obs_wa.size(), obs_done, w); end
  endtask

  task automatic test_retrigger();
    logic [WS-1:0] a, b;
    string tag;
    for (int m = 0; m < 2; m++) begin
      tag = (m == 0) ? "retrig_req" : "retrig_recv";
      clear_logs();
      a = WS'($urandom);
      b = WS'($urandom);
      if (m == 0) begin
        send_trigger(a, WW'(100));
        repeat (3) tick();
        checks++;
        if (rd_req_valid_out !== 1'b1 || rd_req_addr_out !== SA'(a >> 9))
          begin failures++; $display("FAIL %s first_addr got=%h required=%h", tag, rd_req_addr_out, SA'(a >> 9)); end
        send_trigger(b, WW'(300));
        checks++;
        if (rd_req_valid_out !== 1'b1 || rd_req_addr_out !== SA'(b >> 9))
          begin failures++; $display("FAIL %s new_addr got=%h required=%h", tag, rd_req_addr_out, SA'(b >> 9)); end
        serve_request(2);
        feed(512, 1'b0);
        add_expect(b, 1, 300, 0);
      end else begin
        send_trigger(a, WW'(600));
        serve_request(0);
        feed(100, 1'b0);
        send_trigger(b, WW'(8));
        feed(412, 1'b0);
        checks++;
        if (obs_done != 0 || busy_out !== 1'b1)
          begin failures++; $display("FAIL %s aborted_load done=%0d busy=%b required done=0 busy=1", tag, obs_done, busy_out); end
        serve_request(0);
        feed(512, 1'b0);
        add_expect(a, 1, 100, 0);
        exp_sum = '0;
        add_expect(b, 1, 8, 512);
      end
      checks++;
      if (done_out !== 1'b1) begin failures++; $display("FAIL %s done got=%b required=1", tag, done_out); end
      tick();
      checks++;
      if (obs_req.size() != exp_req.size())
        begin failures++; $display("FAIL %s req_count got=%0d required=%0d", tag, obs_req.size(), exp_req.size()); end
      foreach (exp_req[i]) if (i < obs_req.size()) begin
        checks++;
        if (obs_req[i] !== exp_req[i])
          begin failures++; $display("FAIL %s req_addr[%0d] got=%h required=%h", tag, i, obs_req[i], exp_req[i]); end
      end
      checks++;
      if (obs_wa.size() != exp_wa.size())
        begin failures++; $display("FAIL %s write_count got=%0d required=%0d", tag, obs_wa.size(), exp_wa.size()); end
      foreach (exp_wa[i]) if (i < obs_wa.size()) begin
        checks++;
        if ({obs_wa[i], obs_wd[i]} !== {exp_wa[i], exp_wd[i]})
          begin failures++; $display("FAIL %s write[%0d] got=%h/%h required=%h/%h", tag, i, obs_wa[i], obs_wd[i], exp_wa[i], exp_wd[i]); end
      end
      checks++;
      if (obs_done != 1) begin failures++; $display("FAIL %s done_count got=%0d required=1", tag, obs_done); end
`ifdef WAVE_FETCH_CHECKSUM_EN
      checks++;
      if (checksum_out !== exp_sum) begin failures++; $display("FAIL %s checksum got=%h required=%h", tag, checksum_out, exp_sum); end
`endif
    end
  endtask

  task automatic test_reset_mid();
    logic [WS-1:0] b;
    logic [OUTS_W-1:0] outs;
    int w, nsec;
    clear_logs();
    send_trigger(WS'($urandom), WW'(300));
    serve_request(0);
    feed(50, 1'b0);
    rst_in = 1'b1;
    #1;
    outs = {rd_req_valid_out, buf_we_out, busy_out, done_out, rd_req_addr_out, buf_addr_out, buf_data_out};
    checks++;
    if (outs !== '0) begin failures++; $display("FAIL midreset_outputs got=%h required=0", outs); end
    tick();
    rst_in = 1'b0;
    clear_logs();
    feed(462, 1'b0);
    repeat (2) tick();
    checks++;
    if (obs_req.size() != 0 || obs_wa.size() != 0 || obs_busy != 0 || obs_done != 0)
      begin failures++; $display("FAIL midreset_tail req=%0d writes=%0d busy=%0d done=%0d required all 0", obs_req.size(), obs_wa.size(), obs_busy, obs_done); end
    clear_logs();
    b = WS'($urandom);
    w = int'($urandom_range(1, 900));
    nsec = (w + 511) / 512;
    send_trigger(b, WW'(w));
    for (int k = 0; k < nsec; k++) begin
      serve_request(1);
      feed(512, 1'b0);
    end
    checks++;
    if (done_out !== 1'b1) begin failures++; $display("FAIL reload done got=%b required=1", done_out); end
    tick();
    add_expect(b, nsec, w, 0);
    checks++;
    if (obs_req.size() != exp_req.size())
      begin failures++; $display("FAIL reload req_count got=%0d required=%0d", obs_req.size(), exp_req.size()); end
    foreach (exp_req[i]) if (i < obs_req.size()) begin
      checks++;
      if (obs_req[i] !== exp_req[i])
        begin failures++; $display("FAIL reload req_addr[%0d] got=%h required=%h", i, obs_req[i], exp_req[i]); end
    end
    checks++;
    if (obs_wa.size() != exp_wa.size())
      begin failures++; $display("FAIL reload write_count got=%0d required=%0d", obs_wa.size(), exp_wa.size()); end
    foreach (exp_wa[i]) if (i < obs_wa.size()) begin
      checks++;
      if ({obs_wa[i], obs_wd[i]} !== {exp_wa[i], exp_wd[i]})
        begin failures++; $display("FAIL reload write[%0d] got=%h/%h required=%h/%h", i, obs_wa[i], obs_wd[i], exp_wa[i], exp_wd[i]); end
    end
    checks++;
    if (obs_done != 1) begin failures++; $display("FAIL reload done_count got=%0d required=1", obs_done); end
`ifdef WAVE_FETCH_CHECKSUM_EN
    checks++;
    if (checksum_out !== exp_sum) begin failures++; $display("FAIL reload checksum got=%h required=%h", checksum_out, exp_sum); end
`endif
  endtask

  initial begin
    rst_in           = 1'b1;
    update_trig_in   = 1'b0;
    wave_start_in    = '0;
    wave_width_in    = '0;
    rd_req_ready_in  = 1'b0;
    rd_data_valid_in = 1'b0;
    rd_data_in       = '0;
    clear_logs();
    test_reset();
    test_loads();
    test_zero_width();
    test_ready_stall();
    test_retrigger();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
